// File: rtl/commit_trace_buffer.sv
// Retirement-trace capture: filters commit records into a first-word-fall-through FIFO,
// with a PC trigger and post-trigger window, plus drop accounting for a full FIFO.
module commit_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [1:0]                 filter_i,
  input  logic                       trig_en_i,
  input  logic [XLEN-1:0]            trig_pc_i,
  input  logic                       commit_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic                       mem_wrt_i,
  input  logic [XLEN-1:0]            mem_addr_i,
  input  logic [XLEN-1:0]            mem_data_i,
  output logic                       rec_valid_o,
  input  logic                       rec_ready_i,
  output logic [XLEN-1:0]            rec_pc_o,
  output logic [XLEN-1:0]            rec_instr_o,
  output logic [4:0]                 rec_reg_addr_o,
  output logic [XLEN-1:0]            rec_reg_data_o,
  output logic                       rec_mem_wrt_o,
  output logic [XLEN-1:0]            rec_mem_addr_o,
  output logic [XLEN-1:0]            rec_mem_data_o,
  output logic                       rec_trig_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       overflow_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);
  localparam logic [7:0] PostLast = (POST_TRIG == 0) ? 8'd0 : 8'(POST_TRIG - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPost = 2'b10,
    StHalt = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      post_cnt_q, post_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;

  logic [XLEN-1:0] mem_pc_q       [DEPTH];
  logic [XLEN-1:0] mem_instr_q    [DEPTH];
  logic [4:0]      mem_reg_addr_q [DEPTH];
  logic [XLEN-1:0] mem_reg_data_q [DEPTH];
  logic            mem_mem_wrt_q  [DEPTH];
  logic [XLEN-1:0] mem_mem_addr_q [DEPTH];
  logic [XLEN-1:0] mem_mem_data_q [DEPTH];
  logic            mem_trig_q     [DEPTH];

  logic filt_match, is_trig, capturing, qual, full, pop, push, drop, mem_we;

  always_comb begin
    case (filter_i)
      2'b00:   filt_match = 1'b1;
      2'b01:   filt_match = (reg_addr_i != 5'd0);
      2'b10:   filt_match = mem_wrt_i;
      default: filt_match = (reg_addr_i != 5'd0) | mem_wrt_i;
    endcase
    capturing = enable_i & ((state_q == StRun) | (state_q == StPost));
    is_trig   = capturing & (state_q == StRun) & trig_en_i & commit_i & (pc_i == trig_pc_i);
    qual      = capturing & commit_i & (filt_match | is_trig);
    full      = (count_q == Full);
    pop       = (count_q != '0) & rec_ready_i;
    push      = qual & (!full | pop);
    drop      = qual & full & !pop;
    mem_we    = push & !clear_i & !rst_i;
  end

  // Next-state for FSM, pointers and counters; clear flushes but only idles when disabled.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    if (clear_i) begin
      if (!enable_i) state_d = StIdle;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (!enable_i) begin
        state_d = StIdle;
      end else begin
        case (state_q)
          StIdle: state_d = StRun;
          StRun: begin
            if (is_trig) begin
              if (POST_TRIG == 0) begin
                state_d = StHalt;
              end else begin
                state_d    = StPost;
                post_cnt_d = 8'd0;
              end
            end
          end
          StPost: begin
            if (qual) begin
              if (post_cnt_q == PostLast) state_d = StHalt;
              else post_cnt_d = post_cnt_q + 8'd1;
            end
          end
          default: state_d = StHalt;
        endcase
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      overflow_d = overflow_q | drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      post_cnt_q <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; outputs are masked by rec_valid_o instead.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_pc_q[wr_ptr_q]       <= pc_i;
      mem_instr_q[wr_ptr_q]    <= instr_i;
      mem_reg_addr_q[wr_ptr_q] <= reg_addr_i;
      mem_reg_data_q[wr_ptr_q] <= reg_data_i;
      mem_mem_wrt_q[wr_ptr_q]  <= mem_wrt_i;
      mem_mem_addr_q[wr_ptr_q] <= mem_addr_i;
      mem_mem_data_q[wr_ptr_q] <= mem_data_i;
      mem_trig_q[wr_ptr_q]     <= is_trig;
    end
  end

  always_comb begin
    rec_valid_o    = (count_q != '0);
    rec_pc_o       = rec_valid_o ? mem_pc_q[rd_ptr_q]       : '0;
    rec_instr_o    = rec_valid_o ? mem_instr_q[rd_ptr_q]    : '0;
    rec_reg_addr_o = rec_valid_o ? mem_reg_addr_q[rd_ptr_q] : '0;
    rec_reg_data_o = rec_valid_o ? mem_reg_data_q[rd_ptr_q] : '0;
    rec_mem_wrt_o  = rec_valid_o ? mem_mem_wrt_q[rd_ptr_q]  : 1'b0;
    rec_mem_addr_o = rec_valid_o ? mem_mem_addr_q[rd_ptr_q] : '0;
    rec_mem_data_o = rec_valid_o ? mem_mem_data_q[rd_ptr_q] : '0;
    rec_trig_o     = rec_valid_o ? mem_trig_q[rd_ptr_q]     : 1'b0;
    count_o        = count_q;
    drop_cnt_o     = drop_cnt_q;
    overflow_o     = overflow_q;
    state_o        = state_q;
  end

endmodule
